// File: rtl/sample_input_ctrl.sv
// sample_input_ctrl: serial-to-parallel front end for data_memory.
// Collects one MSB-first sample per Frame from InputL, then issues a
// single-cycle write (wr_en/input_rdy_flag) at the circular write pointer,
// and tracks the newest written address and a saturating sample count.
module sample_input_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              Sclk,
   input  logic              Reset,
   input  logic              Frame,
   input  logic              bit_en,
   input  logic              InputL,
   input  logic              clear_ptr,
   output logic [DATA_W-1:0] data_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] data_wr_addr,
   output logic              input_rdy_flag,
   output logic [ADDR_W-1:0] newest_addr,
   output logic [15:0]       sample_cnt,
   output logic              frame_err
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;
   logic [DATA_W-1:0] first_bit_d;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] data_q;
   logic              wr_en_q;
   logic              rdy_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] newest_q;
   logic [15:0]       cnt_q;
   logic [15:0]       cnt_d;
   logic              err_q;
   logic              frame_bit;

   // Next values for the shifter, pointer and saturating sample counter
   always_comb begin
      frame_bit   = Frame & bit_en;
      shift_d     = {shift_q[DATA_W-2:0], InputL};
      first_bit_d = '0;
      first_bit_d[0] = InputL;
      addr_d      = addr_q + ADDR_W'(1);
      cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   end

   // Capture FSM with registered outputs.
   // bit_cnt == DATA_W marks a completed word waiting one edge for its
   // write pulse, so wr_en rises on the edge after the last bit.
   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         wr_en_q   <= 1'b0;
         rdy_q     <= 1'b0;
         addr_q    <= '0;
         newest_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         rdy_q   <= 1'b0;
         if (clear_ptr) begin
            addr_q    <= '0;
            newest_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (frame_bit) begin
                     shift_q   <= first_bit_d;
                     bit_cnt_q <= CNT_W'(1);
                     state_q   <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (bit_cnt_q == CNT_W'(DATA_W)) begin
                     data_q    <= shift_q;
                     wr_en_q   <= 1'b1;
                     rdy_q     <= 1'b1;
                     bit_cnt_q <= '0;
                     state_q   <= WRITE;
                  end else if (bit_en) begin
                     if (Frame) begin
                        err_q     <= 1'b1;
                        shift_q   <= first_bit_d;
                        bit_cnt_q <= CNT_W'(1);
                     end else begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
               end
               WRITE: begin
                  newest_q <= addr_q;
                  addr_q   <= addr_d;
                  cnt_q    <= cnt_d;
                  if (frame_bit) begin
                     shift_q   <= first_bit_d;
                     bit_cnt_q <= CNT_W'(1);
                     state_q   <= SHIFT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  bit_cnt_q <= '0;
                  state_q   <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_in        = data_q;
   assign wr_en          = wr_en_q;
   assign input_rdy_flag = rdy_q;
   assign data_wr_addr   = addr_q;
   assign newest_addr    = newest_q;
   assign sample_cnt     = cnt_q;
   assign frame_err      = err_q;

endmodule

// File: tb/tb_sample_input_ctrl.sv
// Bench for sample_input_ctrl: directed scenarios plus random serial traffic,
// all checked cycle by cycle against a word-level reference model.
module tb_sample_input_ctrl;

   logic        Sclk = 1'b0;
   logic        Reset = 1'b1;
   logic        Frame = 1'b0;
   logic        bit_en = 1'b0;
   logic        InputL = 1'b0;
   logic        clear_ptr = 1'b0;
   logic [15:0] data_in;
   logic        wr_en;
   logic [7:0]  data_wr_addr;
   logic        input_rdy_flag;
   logic [7:0]  newest_addr;
   logic [15:0] sample_cnt;
   logic        frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state (word level)
   logic [15:0] m_data;
   logic        m_pulse;
   logic [7:0]  m_addr;
   logic [7:0]  m_newest;
   logic [15:0] m_cnt;
   logic        m_err;
   logic [15:0] m_word;
   int          m_nbits;
   logic        m_pending;

   sample_input_ctrl #(.DATA_W(16), .ADDR_W(8)) dut (
      .Sclk           (Sclk),
      .Reset          (Reset),
      .Frame          (Frame),
      .bit_en         (bit_en),
      .InputL         (InputL),
      .clear_ptr      (clear_ptr),
      .data_in        (data_in),
      .wr_en          (wr_en),
      .data_wr_addr   (data_wr_addr),
      .input_rdy_flag (input_rdy_flag),
      .newest_addr    (newest_addr),
      .sample_cnt     (sample_cnt),
      .frame_err      (frame_err)
   );

   always #5 Sclk = ~Sclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, ".data_in"},   32'(data_in),        32'(m_data));
      check({ph, ".wr_en"},     32'(wr_en),          32'(m_pulse));
      check({ph, ".rdy"},       32'(input_rdy_flag), 32'(m_pulse));
      check({ph, ".addr"},      32'(data_wr_addr),   32'(m_addr));
      check({ph, ".newest"},    32'(newest_addr),    32'(m_newest));
      check({ph, ".cnt"},       32'(sample_cnt),     32'(m_cnt));
      check({ph, ".frame_err"}, 32'(frame_err),      32'(m_err));
   endtask

   task automatic model_reset();
      m_data = '0; m_pulse = 0; m_addr = '0; m_newest = '0; m_cnt = '0;
      m_err = 0; m_word = '0; m_nbits = 0; m_pending = 0;
   endtask

   // One clock edge as seen by the model: a finished word is written on the
   // edge after its last bit, the write cycle then bumps pointer and count.
   task automatic model_edge(input logic f, input logic b, input logic d, input logic c);
      logic nxt_pulse;
      nxt_pulse = 0;
      if (c) begin
         m_addr = '0; m_newest = '0; m_cnt = '0; m_err = 0;
         m_nbits = 0; m_pending = 0;
      end else begin
         if (m_pulse) begin
            m_newest = m_addr;
            m_addr   = m_addr + 8'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         if (m_pending) begin
            m_data    = m_word;
            nxt_pulse = 1;
            m_pending = 0;
         end else if (b) begin
            if (f) begin
               if (m_nbits > 0) m_err = 1;
               m_word  = {15'd0, d};
               m_nbits = 1;
            end else if (m_nbits > 0) begin
               m_word  = {m_word[14:0], d};
               m_nbits = m_nbits + 1;
               if (m_nbits == 16) begin
                  m_pending = 1;
                  m_nbits   = 0;
               end
            end
         end
      end
      m_pulse = nxt_pulse;
   endtask

   task automatic cycle(input logic f, input logic b, input logic d, input logic c);
      Frame = f; bit_en = b; InputL = d; clear_ptr = c;
      @(posedge Sclk);
      model_edge(f, b, d, c);
      #1;
      check_all("cyc");
   endtask

   task automatic do_reset();
      Frame = 0; bit_en = 0; InputL = 0; clear_ptr = 0;
      Reset = 1;
      #2;
      model_reset();
      check_all("rst_async");
      @(posedge Sclk);
      #1;
      check_all("rst_hold");
      Reset = 0;
   endtask

   // n bits of val (MSB of the n-bit field first), first bit framed,
   // each bit preceded by gap-1 cycles with bit_en low
   task automatic send_bits(input logic [15:0] val, input int n, input int gap);
      logic [15:0] v;
      v = val;
      for (int i = n - 1; i >= 0; i--) begin
         for (int g = 1; g < gap; g++) cycle(0, 0, 0, 0);
         cycle(i == n - 1, 1, v[i], 0);
      end
   endtask

   initial begin
      do_reset();

      // 1: single word, write pulse one edge after the last bit
      send_bits(16'hA5C3, 16, 1);
      check("t1.no_early_wr", 32'(wr_en), 32'd0);
      cycle(0, 0, 0, 0);
      check("t1.wr_en", 32'(wr_en), 32'd1);
      check("t1.data", 32'(data_in), 32'h0000A5C3);
      check("t1.addr_pulse", 32'(data_wr_addr), 32'd0);
      cycle(0, 0, 0, 0);
      check("t1.wr_low", 32'(wr_en), 32'd0);
      check("t1.addr_after", 32'(data_wr_addr), 32'd1);
      check("t1.newest", 32'(newest_addr), 32'd0);
      check("t1.cnt", 32'(sample_cnt), 32'd1);

      // 2: 256 frames at 17-cycle spacing, pointer wraps
      do_reset();
      for (int k = 0; k < 256; k++) begin
         send_bits(16'(k), 16, 1);
         cycle(0, 0, 0, 0);
      end
      cycle(0, 0, 0, 0);
      check("t2.newest", 32'(newest_addr), 32'd255);
      check("t2.addr_wrap", 32'(data_wr_addr), 32'd0);
      check("t2.cnt", 32'(sample_cnt), 32'd256);
      check("t2.no_err", 32'(frame_err), 32'd0);
      check("t2.data", 32'(data_in), 32'd255);

      // 3: early Frame after 7 bits
      do_reset();
      send_bits(16'h005A, 7, 1);
      send_bits(16'h1234, 16, 1);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check("t3.err", 32'(frame_err), 32'd1);
      check("t3.data", 32'(data_in), 32'h1234);
      check("t3.cnt", 32'(sample_cnt), 32'd1);

      // 4: gapped bit_en, then stray unframed bits in IDLE
      do_reset();
      send_bits(16'h8001, 16, 3);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 1'($urandom), 0);
      check("t4.data", 32'(data_in), 32'h8001);
      check("t4.cnt", 32'(sample_cnt), 32'd1);

      // 5: clear_ptr during the write cycle of sample 5
      do_reset();
      for (int k = 0; k < 4; k++) begin
         send_bits(16'(16'h0100 + k), 16, 1);
         cycle(0, 0, 0, 0);
      end
      send_bits(16'h0BEE, 16, 1);
      cycle(0, 0, 0, 0);
      check("t5.wr_en", 32'(wr_en), 32'd1);
      check("t5.addr4", 32'(data_wr_addr), 32'd4);
      cycle(0, 0, 0, 1);
      check("t5.addr0", 32'(data_wr_addr), 32'd0);
      check("t5.cnt0", 32'(sample_cnt), 32'd0);
      check("t5.newest0", 32'(newest_addr), 32'd0);
      check("t5.data_kept", 32'(data_in), 32'h0BEE);

      // 6: reset after 10 bits, then a full frame lands at address 0
      send_bits(16'h03FF, 10, 1);
      do_reset();
      check("t6.wr_en", 32'(wr_en), 32'd0);
      cycle(0, 0, 0, 0);
      send_bits(16'hC0DE, 16, 1);
      cycle(0, 0, 0, 0);
      check("t6.addr_pulse", 32'(data_wr_addr), 32'd0);
      check("t6.data", 32'(data_in), 32'hC0DE);
      cycle(0, 0, 0, 0);
      check("t6.cnt", 32'(sample_cnt), 32'd1);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(999) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(24) == 0, $urandom_range(2) != 0,
                  1'($urandom), $urandom_range(299) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
